// File: rtl/grid_pkg.sv
// grid_pkg: definitions shared by the grid bus arbiter and its channel picker.
//   grid_mode_e  : arbitration mode encodings (3 is reserved and behaves as round-robin)
//   GRID_NUM_CH  : default number of producer channels
//   GRID_MAX_W   : widest supported data word
//   rotl1()      : rotate-left-by-one of a w-bit value, carried in a GRID_MAX_W container
package grid_pkg;

    typedef enum logic [1:0] {
        MODE_RR   = 2'd0,
        MODE_PRIO = 2'd1,
        MODE_XOR  = 2'd2,
        MODE_RSVD = 2'd3
    } grid_mode_e;

    localparam int GRID_NUM_CH = 12;
    localparam int GRID_MAX_W  = 64;

    // Bits at and above w in the argument must be zero; the result is masked to w bits.
    function automatic logic [GRID_MAX_W-1:0] rotl1(input logic [GRID_MAX_W-1:0] v,
                                                   input int unsigned            w);
        logic [GRID_MAX_W-1:0] mask;
        mask  = (w >= GRID_MAX_W) ? '1 : ((64'd1 << w) - 64'd1);
        rotl1 = ((v << 1) | (v >> (w - 1))) & mask;
    endfunction

endpackage

// File: rtl/grid_rr_pick.sv
// grid_rr_pick: combinational channel selector.
//   valid     in  NUM_CH  per-channel request
//   start     in  CH_W    first channel examined (round-robin pointer)
//   prio_mode in  1       1 = fixed priority (search starts at channel 0)
//   grant     out NUM_CH  one-hot winner, all zero when nothing is valid
//   any       out 1       at least one channel is valid
module grid_rr_pick
    import grid_pkg::*;
#(
    parameter int NUM_CH = GRID_NUM_CH,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] valid,
    input  logic [CH_W-1:0]   start,
    input  logic              prio_mode,
    output logic [NUM_CH-1:0] grant,
    output logic              any
);

    int eff_start;

    // Two passes: channels at or above the start pointer first, then the
    // wrapped-around channels below it. The first valid channel wins.
    always_comb begin
        grant     = '0;
        any       = 1'b0;
        eff_start = prio_mode ? 0 : int'(start);
        for (int i = 0; i < NUM_CH; i++) begin
            if (!any && valid[i] && (i >= eff_start)) begin
                grant[i] = 1'b1;
                any      = 1'b1;
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (!any && valid[i] && (i < eff_start)) begin
                grant[i] = 1'b1;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/grid_bus_arbiter.sv
// grid_bus_arbiter: shared-bus arbiter collecting result words from NUM_CH producers.
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   mode         0/3 round-robin, 1 fixed priority, 2 XOR-reduce of all channels
//   req_valid    per-channel word valid
//   req_data     channel i at [i*DATA_W +: DATA_W]
//   req_ready    per-channel accept (combinational)
//   out_valid    output register holds a word
//   out_data     granted word, or XOR of all words in reduce mode
//   out_ch       granted channel index (0 for a reduce beat)
//   out_ready    downstream accept
//   sig_clr      synchronous signature clear (applied before folding a same-cycle word)
//   sig          running rotate-XOR signature of accepted words
//   xfer_cnt     accepted-transfer count, wraps
module grid_bus_arbiter
    import grid_pkg::*;
#(
    parameter int NUM_CH = GRID_NUM_CH,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16,
    localparam int CH_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               mode,
    input  logic [NUM_CH-1:0]        req_valid,
    input  logic [NUM_CH*DATA_W-1:0] req_data,
    output logic [NUM_CH-1:0]        req_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch,
    input  logic                     out_ready,
    input  logic                     sig_clr,
    output logic [DATA_W-1:0]        sig,
    output logic [CNT_W-1:0]         xfer_cnt
);

    // Stage 0: selection, reduce tree and accept decision (combinational)
    logic                vld_p1;
    logic [DATA_W-1:0]   data_p1;
    logic [CH_W-1:0]     ch_p1;
    logic [DATA_W-1:0]   sig_p1;
    logic [CNT_W-1:0]    cnt_p1;
    logic [CH_W-1:0]     rr_ptr;

    logic                slot_free;
    logic                xor_mode;
    logic                prio_mode;
    logic                all_valid;
    logic [NUM_CH-1:0]   grant;
    logic                grant_any;
    logic [CH_W-1:0]     grant_idx;
    logic [CH_W-1:0]     rr_next;
    logic [DATA_W-1:0]   grant_word;
    logic [DATA_W-1:0]   xor_word;
    logic [DATA_W-1:0]   accept_word;
    logic                accept;
    logic [DATA_W-1:0]   sig_base;

    assign slot_free = !vld_p1 || out_ready;
    assign xor_mode  = (mode == MODE_XOR);
    assign prio_mode = (mode == MODE_PRIO);
    assign all_valid = &req_valid;

    grid_rr_pick #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_pick (
        .valid     (req_valid),
        .start     (rr_ptr),
        .prio_mode (prio_mode),
        .grant     (grant),
        .any       (grant_any)
    );

    always_comb begin
        grant_idx  = '0;
        grant_word = '0;
        xor_word   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            xor_word = xor_word ^ req_data[i*DATA_W +: DATA_W];
            if (grant[i]) begin
                grant_idx  = CH_W'(i);
                grant_word = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign rr_next = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;

    // Ready is gated by reset so no producer sees a handshake while the
    // output side is being cleared.
    always_comb begin
        req_ready = '0;
        if (rst_n && slot_free) begin
            if (xor_mode) begin
                req_ready = all_valid ? '1 : '0;
            end else begin
                req_ready = grant;
            end
        end
    end

    assign accept      = rst_n && slot_free && (xor_mode ? all_valid : grant_any);
    assign accept_word = xor_mode ? xor_word : grant_word;
    assign sig_base    = sig_clr ? '0 : DATA_W'(rotl1(GRID_MAX_W'(sig_p1), DATA_W));

    // Stage 1: output register, signature, transfer counter, round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            ch_p1   <= '0;
            sig_p1  <= '0;
            cnt_p1  <= '0;
            rr_ptr  <= '0;
        end else begin
            if (accept) begin
                vld_p1  <= 1'b1;
                data_p1 <= accept_word;
                ch_p1   <= xor_mode ? '0 : grant_idx;
                cnt_p1  <= cnt_p1 + 1'b1;
                sig_p1  <= sig_base ^ accept_word;
                if (!xor_mode && !prio_mode) begin
                    rr_ptr <= rr_next;
                end
            end else begin
                if (out_ready) begin
                    vld_p1 <= 1'b0;
                end
                if (sig_clr) begin
                    sig_p1 <= '0;
                end
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign out_ch    = ch_p1;
    assign sig       = sig_p1;
    assign xfer_cnt  = cnt_p1;

endmodule

// File: tb/tb_grid_bus_arbiter.sv
// Directed bench for grid_bus_arbiter with NUM_CH=4, DATA_W=8.
module tb_grid_bus_arbiter;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;
    localparam int CH_W   = 2;

    logic                     clk;
    logic                     rst_n;
    logic [1:0]               mode;
    logic [NUM_CH-1:0]        req_valid;
    logic [NUM_CH*DATA_W-1:0] req_data;
    logic [NUM_CH-1:0]        req_ready;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic [CH_W-1:0]          out_ch;
    logic                     out_ready;
    logic                     sig_clr;
    logic [DATA_W-1:0]        sig;
    logic [CNT_W-1:0]         xfer_cnt;

    int checks;
    int failures;

    grid_bus_arbiter #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready),
        .sig_clr   (sig_clr),
        .sig       (sig),
        .xfer_cnt  (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_words(input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [7:0] d3);
        req_data = {d3, d2, d1, d0};
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        mode      = 2'd0;
        req_valid = 4'hF;
        out_ready = 1'b1;
        sig_clr   = 1'b0;
        set_words(8'h10, 8'h11, 8'h12, 8'h13);

        // Reset state, with requests pending to show ready stays low in reset
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data",  32'(out_data),  32'h0);
        check("rst_out_ch",    32'(out_ch),    32'h0);
        check("rst_sig",       32'(sig),       32'h0);
        check("rst_xfer_cnt",  32'(xfer_cnt),  32'h0);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        rst_n = 1'b1;
        #1;

        // Round-robin fairness: 0,1,2,3,0
        check("rr_ready_first", 32'(req_ready), 32'h1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("rr_ch_%0d", k),   32'(out_ch),   32'(k % 4));
            check($sformatf("rr_data_%0d", k), 32'(out_data), 32'h10 + 32'(k % 4));
        end
        req_valid = 4'h0;
        check("rr_cnt5", 32'(xfer_cnt), 32'd5);
        tick();
        check("rr_drain_valid", 32'(out_valid), 32'h0);
        check("rr_drain_hold",  32'(out_data),  32'h10);
        check("rr_ptr_after",   32'(dut.rr_ptr), 32'd1);

        // Fixed priority: channel 1 always beats channel 3
        mode      = 2'd1;
        req_valid = 4'b1010;
        set_words(8'h20, 8'h21, 8'h22, 8'h23);
        #1;
        check("prio_ready", 32'(req_ready), 32'b0010);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("prio_ch_%0d", k), 32'(out_ch), 32'd1);
            check($sformatf("prio_rdy_%0d", k), 32'(req_ready), 32'b0010);
        end
        check("prio_ptr_held", 32'(dut.rr_ptr), 32'd1);
        check("prio_cnt", 32'(xfer_cnt), 32'd9);
        req_valid = 4'h0;
        tick();

        // XOR-reduce gating
        mode      = 2'd2;
        req_valid = 4'b0111;
        set_words(8'h01, 8'h02, 8'h04, 8'h08);
        #1;
        check("xor_partial_ready", 32'(req_ready), 32'h0);
        tick();
        check("xor_partial_ready2", 32'(req_ready), 32'h0);
        check("xor_partial_valid",  32'(out_valid), 32'h0);
        req_valid = 4'hF;
        #1;
        check("xor_full_ready", 32'(req_ready), 32'hF);
        tick();
        req_valid = 4'h0;
        check("xor_data",  32'(out_data),  32'h0F);
        check("xor_ch",    32'(out_ch),    32'h0);
        check("xor_valid", 32'(out_valid), 32'h1);
        check("xor_cnt",   32'(xfer_cnt),  32'd10);
        #1;
        check("xor_ready_off", 32'(req_ready), 32'h0);
        tick();
        check("xor_drain", 32'(out_valid), 32'h0);

        // Backpressure: hold for 5 cycles, then grant in the release cycle
        mode      = 2'd0;
        req_valid = 4'hF;
        out_ready = 1'b0;
        set_words(8'h10, 8'h11, 8'h12, 8'h13);
        tick();
        check("bp_first_ch", 32'(out_ch), 32'd1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("bp_ready_%0d", k), 32'(req_ready), 32'h0);
            check($sformatf("bp_valid_%0d", k), 32'(out_valid), 32'h1);
            check($sformatf("bp_data_%0d", k),  32'(out_data),  32'h11);
            check($sformatf("bp_ch_%0d", k),    32'(out_ch),    32'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = 4'h0;
        check("bp_next_ch",   32'(out_ch),   32'd2);
        check("bp_next_data", 32'(out_data), 32'h12);
        check("bp_cnt",       32'(xfer_cnt), 32'd12);
        tick();

        // Signature: clear alone, fold 0x01, 0x80, then clear-and-fold 0x55
        sig_clr = 1'b1;
        tick();
        check("sig_clr_alone", 32'(sig), 32'h0);
        sig_clr   = 1'b0;
        mode      = 2'd1;
        req_valid = 4'b0001;
        set_words(8'h01, 8'h00, 8'h00, 8'h00);
        tick();
        check("sig_01", 32'(sig), 32'h01);
        set_words(8'h80, 8'h00, 8'h00, 8'h00);
        tick();
        check("sig_82", 32'(sig), 32'h82);
        set_words(8'h55, 8'h00, 8'h00, 8'h00);
        sig_clr = 1'b1;
        tick();
        check("sig_clr_fold", 32'(sig), 32'h55);
        check("sig_cnt", 32'(xfer_cnt), 32'd15);
        sig_clr   = 1'b0;
        req_valid = 4'h0;
        tick();

        // Reset mid-operation with a word held and rr_ptr=2
        mode      = 2'd0;
        req_valid = 4'b0010;
        out_ready = 1'b0;
        set_words(8'h10, 8'h11, 8'h12, 8'h13);
        tick();
        req_valid = 4'h0;
        check("mid_valid", 32'(out_valid), 32'h1);
        check("mid_ptr",   32'(dut.rr_ptr), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'h0);
        check("arst_data",  32'(out_data),  32'h0);
        check("arst_ch",    32'(out_ch),    32'h0);
        check("arst_sig",   32'(sig),       32'h0);
        check("arst_cnt",   32'(xfer_cnt),  32'h0);
        check("arst_ptr",   32'(dut.rr_ptr), 32'h0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        req_valid = 4'hF;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'b0001);
        tick();
        req_valid = 4'h0;
        check("post_rst_ch",   32'(out_ch),   32'd0);
        check("post_rst_data", 32'(out_data), 32'h10);
        check("post_rst_cnt",  32'(xfer_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/grid_bus_arbiter.md
# grid_bus_arbiter

Parametrised shared-bus arbiter that replaces the flat global-XOR combine in the grid top level. It collects result words from NUM_CH producers (cores, L3 banks, RAM controllers) over valid/ready channels and grants one per cycle, or reduces all of them in one beat. It drives a single registered output port and keeps a running rotate-XOR signature of every accepted word. The top level maps `out_data[7:0]` or `sig[7:0]` to the pad outputs.

## Interface
- `NUM_CH`, default 12: number of producer channels, 2..16.
- `DATA_W`, default 32: word width, 8..64.
- `CNT_W`, default 16: width of the transfer counter.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `mode`  in  2  arbitration mode: 0 = round-robin, 1 = fixed priority, 2 = XOR-reduce, 3 = treated as 0.
- `req_valid`  in  NUM_CH  per-channel word valid.
- `req_data`  in  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- `req_ready`  out  NUM_CH  per-channel accept, combinational.
- `out_valid`  out  1  output register holds a word.
- `out_data`  out  DATA_W  granted word, or XOR of all words in mode 2.
- `out_ch`  out  CH_W  granted channel index; 0 in mode 2. CH_W = $clog2(NUM_CH).
- `out_ready`  in  1  downstream accept.
- `sig_clr`  in  1  synchronous clear of the signature.
- `sig`  out  DATA_W  running signature.
- `xfer_cnt`  out  CNT_W  accepted-transfer count, wraps.

## Operation
- **Slot free:** `slot_free = !out_valid || out_ready`. No channel is granted unless the slot is free.
- **Round-robin (mode 0/3):**
  - Search starts at `rr_ptr` and wraps modulo NUM_CH; the first valid channel wins.
  - On grant, `rr_ptr <= (grant+1) mod NUM_CH`.
  - The pointer holds when nothing is granted.
- **Fixed priority (mode 1):**
  - The lowest-index valid channel wins.
  - `rr_ptr` is not updated.
- **XOR-reduce (mode 2):**
  - Fires only when every `req_valid` bit is 1 and the slot is free.
  - All `req_ready` bits assert in the same cycle.
  - `out_data` = XOR of all NUM_CH words.
  - If any channel is not valid, no `req_ready` asserts. This mode never grants partially.
- **Handshake:**
  - `req_ready[i]` is high only for the granted channel(s) in that cycle.
  - A transfer occurs on `req_valid[i] && req_ready[i]`.
  - A granted channel must be valid; `req_ready` never asserts for an invalid channel.
- **Accept:** one event per cycle, covering both a single grant and a reduce.
  - `out_valid <= 1`.
  - `out_data` and `out_ch` load.
  - `xfer_cnt <= xfer_cnt + 1`, wrapping at 2^CNT_W.
  - `sig <= rotl1(sig) ^ word`, where word is the value loaded into `out_data`.
- **Drain:** `out_ready && out_valid` with no new accept gives `out_valid <= 0`. `out_data` and `out_ch` hold their last values.
- **Signature clear:**
  - `sig_clr` alone gives `sig <= 0`.
  - `sig_clr` together with an accept gives `sig <= word`: clear first, then fold.
- **Mode changes:**
  - `mode` is sampled every cycle.
  - A change mid-stream does not affect a word already in the output register.
  - `rr_ptr` is preserved across mode changes.

## Timing
- **Reset values** (async on `rst_n` low): `out_valid=0`, `out_data=0`, `out_ch=0`, `sig=0`, `xfer_cnt=0`, `rr_ptr=0`. `req_ready` = 0 while in reset.
- **Latency:** 1 cycle from the accepting edge to `out_valid`/`out_data`.
- **Throughput:** with `out_ready` held high, 1 word per cycle. Back-to-back accept and drain in the same cycle is legal.
- **Backpressure:** `out_valid && !out_ready` forces all `req_ready` to 0. The output register holds stable until the handshake completes.
- **Combinational paths:** `req_ready` depends combinationally on `req_valid`, `mode`, `out_valid` and `out_ready`. No other combinational input-to-output path exists.
- **Reset mid-operation:** a pending output word is discarded. No partial reduce survives reset.

## Structure
- **Shared package `grid_pkg`:**
  - mode encodings `MODE_RR=2'd0`, `MODE_PRIO=2'd1`, `MODE_XOR=2'd2`.
  - `rotl1` function.
  - Default channel count `GRID_NUM_CH=12`.
- **Sub-module `grid_rr_pick`:** combinational, parametrised on NUM_CH.
  - Inputs: valid vector, start pointer, `prio_mode`.
  - Outputs: one-hot grant and `any`.
  - Implements both round-robin and fixed-priority selection (fixed priority = start pointer forced to 0).
- **Top level:** the output register, signature, counter, pointer and XOR-reduce tree.

## Test plan
- **Round-robin fairness:** NUM_CH=4, mode 0, all valid continuously, `out_ready=1`, data i = 0x10+i → `out_ch` sequence 0,1,2,3,0; `xfer_cnt`=5 after 5 accepts.
- **Fixed priority and starvation:** mode 1, channels 1 and 3 valid → channel 1 is granted every cycle and channel 3 never; `rr_ptr` stays unchanged.
- **XOR-reduce gating:** mode 2, NUM_CH=4, words 0x1,0x2,0x4 with channel 3 invalid → no `req_ready`. Channel 3 = 0x8 raised → one beat with `out_data`=0xF, all `req_ready` high for one cycle, `out_ch`=0.
- **Backpressure:** `out_ready=0` after the first accept → `out_valid`, `out_data` and `out_ch` hold for 5 cycles with `req_ready`=0. `out_ready` raised → next grant in the same cycle.
- **Signature:** DATA_W=8, accepts 0x01 then 0x80 → `sig`=0x01, then 0x82. Next accept of 0x55 with `sig_clr` high → `sig`=0x55.
- **Reset mid-operation:** assert `rst_n`=0 while `out_valid`=1 and `rr_ptr`=2 → all outputs return to reset values asynchronously. The first grant after release goes to channel 0.
